// File: rtl/tron_pkg.sv
// Shared types for the player direction encoder: direction codes, game
// states and the direction helpers used by request capture.
package tron_pkg;

  localparam int unsigned DIR_W = 4;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [DIR_W-1:0] {
    DIR_STOP  = 4'b0000,
    DIR_LEFT  = 4'b0001,
    DIR_RIGHT = 4'b0010,
    DIR_UP    = 4'b0100,
    DIR_DOWN  = 4'b1000
  } dir_t;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_OVER  = 2'd2,
    ST_PAUSE = 2'd3
  } game_state_t;

  // Direction that would reverse the snake onto itself.
  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_LEFT:  opposite = DIR_RIGHT;
      DIR_RIGHT: opposite = DIR_LEFT;
      DIR_UP:    opposite = DIR_DOWN;
      DIR_DOWN:  opposite = DIR_UP;
      default:   opposite = DIR_STOP;
    endcase
  endfunction

  // Resolves simultaneous presses {down,up,right,left}: up > down > left > right.
  function automatic dir_t pick_request(input logic [DIR_W-1:0] press);
    if (press[2])      pick_request = DIR_UP;
    else if (press[3]) pick_request = DIR_DOWN;
    else if (press[0]) pick_request = DIR_LEFT;
    else if (press[1]) pick_request = DIR_RIGHT;
    else               pick_request = DIR_STOP;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counter debouncer for one raw button.
// level flips after DEBOUNCE_CYCLES consecutive synchronized samples differ
// from it; rise pulses for one cycle together with a 0->1 flip.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // Synchronize, count disagreeing samples, flip the level when the count completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        rise  <= sync[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/player_dir_encoder.sv
// Player direction encoder: debounces the player/start buttons, captures
// legal direction requests into per-player pending registers and commits
// them on frame_tick under control of the game FSM.
// Optional feature macro: PAUSE_EN (pause button toggles RUN <-> PAUSE).
module player_dir_encoder
  import tron_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter dir_t        P1_INIT_DIR     = DIR_RIGHT,
  parameter dir_t        P2_INIT_DIR     = DIR_LEFT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [DIR_W-1:0]   p1_btn,
  input  logic [DIR_W-1:0]   p2_btn,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               collision,
  output logic [DIR_W-1:0]   p1_info,
  output logic [DIR_W-1:0]   p2_info,
  output logic               dflt,
  output logic [STATE_W-1:0] game_state
);

  logic [DIR_W-1:0] p1_rise, p1_level, p2_rise, p2_level;
  logic [DIR_W-1:0] p1_press, p2_press;
  logic             start_rise, start_level, start_press;

  // Per-button debouncers for both players.
  for (genvar i = 0; i < DIR_W; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_p1 (
      .clock(clock), .reset(reset), .raw(p1_btn[i]), .level(p1_level[i]), .rise(p1_rise[i])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_p2 (
      .clock(clock), .reset(reset), .raw(p2_btn[i]), .level(p2_level[i]), .rise(p2_rise[i])
    );
  end

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_start (
    .clock(clock), .reset(reset), .raw(start_btn), .level(start_level), .rise(start_rise)
  );

  // A rise always coincides with a high level; qualifying by level keeps both outputs in use.
  assign p1_press    = p1_rise & p1_level;
  assign p2_press    = p2_rise & p2_level;
  assign start_press = start_rise & start_level;

`ifdef PAUSE_EN
  logic pause_rise, pause_level, pause_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_pause (
    .clock(clock), .reset(reset), .raw(pause_btn), .level(pause_level), .rise(pause_rise)
  );

  assign pause_press = pause_rise & pause_level;
`else
  logic pause_unused;

  assign pause_unused = pause_btn;
`endif

  game_state_t state, state_n;
  dir_t        out1, out1_n, out2, out2_n;
  dir_t        pend1, pend1_n, pend2, pend2_n;
  dir_t        com1, com1_n, com2, com2_n;
  dir_t        req1, req2;
  logic        armed, armed_n;
  logic        dflt_q, dflt_n;

  // State, committed outputs, pending requests and dflt registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      out1   <= DIR_STOP;
      out2   <= DIR_STOP;
      pend1  <= DIR_STOP;
      pend2  <= DIR_STOP;
      com1   <= DIR_STOP;
      com2   <= DIR_STOP;
      armed  <= 1'b0;
      dflt_q <= 1'b1;
    end else begin
      state  <= state_n;
      out1   <= out1_n;
      out2   <= out2_n;
      pend1  <= pend1_n;
      pend2  <= pend2_n;
      com1   <= com1_n;
      com2   <= com2_n;
      armed  <= armed_n;
      dflt_q <= dflt_n;
    end
  end

  // Game FSM: next state, request capture and frame-boundary commit.
  always_comb begin
    state_n = state;
    out1_n  = out1;
    out2_n  = out2;
    pend1_n = pend1;
    pend2_n = pend2;
    com1_n  = com1;
    com2_n  = com2;
    armed_n = armed;
    dflt_n  = dflt_q;
    req1    = pick_request(p1_press);
    req2    = pick_request(p2_press);

    case (state)
      ST_IDLE: begin
        out1_n = DIR_STOP;
        out2_n = DIR_STOP;
        dflt_n = 1'b1;
        if (armed) begin
          dflt_n = 1'b0;
          if (frame_tick) begin
            out1_n  = pend1;
            out2_n  = pend2;
            com1_n  = pend1;
            com2_n  = pend2;
            armed_n = 1'b0;
            state_n = ST_RUN;
          end
        end else if (start_press) begin
          pend1_n = P1_INIT_DIR;
          pend2_n = P2_INIT_DIR;
          com1_n  = DIR_STOP;
          com2_n  = DIR_STOP;
          armed_n = 1'b1;
          dflt_n  = 1'b0;
        end
      end

      ST_RUN: begin
        dflt_n = 1'b0;
        if (collision) begin
          out1_n  = DIR_STOP;
          out2_n  = DIR_STOP;
          state_n = ST_OVER;
        end else begin
          if (frame_tick) begin
            out1_n = pend1;
            out2_n = pend2;
            com1_n = pend1;
            com2_n = pend2;
          end
          if (req1 != DIR_STOP && req1 != opposite(com1)) pend1_n = req1;
          if (req2 != DIR_STOP && req2 != opposite(com2)) pend2_n = req2;
`ifdef PAUSE_EN
          if (pause_press) begin
            out1_n  = DIR_STOP;
            out2_n  = DIR_STOP;
            state_n = ST_PAUSE;
          end
`endif
        end
      end

      ST_OVER: begin
        out1_n = DIR_STOP;
        out2_n = DIR_STOP;
        dflt_n = 1'b0;
        if (start_press) begin
          pend1_n = DIR_STOP;
          pend2_n = DIR_STOP;
          com1_n  = DIR_STOP;
          com2_n  = DIR_STOP;
          armed_n = 1'b0;
          dflt_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end

      ST_PAUSE: begin
`ifdef PAUSE_EN
        out1_n = DIR_STOP;
        out2_n = DIR_STOP;
        dflt_n = 1'b0;
        if (req1 != DIR_STOP && req1 != opposite(com1)) pend1_n = req1;
        if (req2 != DIR_STOP && req2 != opposite(com2)) pend2_n = req2;
        if (pause_press) state_n = ST_RUN;
`else
        state_n = ST_IDLE;
`endif
      end
    endcase
  end

  assign p1_info    = out1;
  assign p2_info    = out2;
  assign dflt       = dflt_q;
  assign game_state = state;

endmodule

// File: tb/tb_player_dir_encoder.sv
// Directed bench for player_dir_encoder with a short debounce window.
// Define PAUSE_EN to also exercise the pause scenario.
module tb_player_dir_encoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [3:0] p1_btn = 4'b0000;
  logic [3:0] p2_btn = 4'b0000;
  logic       start_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic       collision = 1'b0;
  logic [3:0] p1_info, p2_info;
  logic       dflt;
  logic [1:0] game_state;

  int checks = 0;
  int errors = 0;

  player_dir_encoder #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3),
    .P1_INIT_DIR(tron_pkg::DIR_RIGHT),
    .P2_INIT_DIR(tron_pkg::DIR_LEFT)
  ) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .p1_btn(p1_btn), .p2_btn(p2_btn), .start_btn(start_btn), .pause_btn(pause_btn),
    .collision(collision), .p1_info(p1_info), .p2_info(p2_info), .dflt(dflt),
    .game_state(game_state)
  );

  always #5 clock = ~clock;

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Hold a button pattern 8 cycles, then release for 10 so the debouncer settles.
  task automatic press_p1(input logic [3:0] v);
    @(negedge clock); p1_btn = v; cycles(8); p1_btn = 4'b0000; cycles(10);
  endtask

  task automatic press_p2(input logic [3:0] v);
    @(negedge clock); p2_btn = v; cycles(8); p2_btn = 4'b0000; cycles(10);
  endtask

  task automatic press_start();
    @(negedge clock); start_btn = 1'b1; cycles(8); start_btn = 1'b0; cycles(10);
  endtask

  task automatic press_pause();
    @(negedge clock); pause_btn = 1'b1; cycles(8); pause_btn = 1'b0; cycles(10);
  endtask

  // One-cycle frame tick; returns at the negedge after the committing edge.
  task automatic tick();
    @(negedge clock); frame_tick = 1'b1; @(negedge clock); frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; p1_btn = 4'b1111; cycles(3);
    checks++; if (p1_info !== 4'b0000) begin errors++; $display("FAIL reset_p1: got %b expected 0000", p1_info); end
    checks++; if (p2_info !== 4'b0000) begin errors++; $display("FAIL reset_p2: got %b expected 0000", p2_info); end
    checks++; if (dflt !== 1'b1) begin errors++; $display("FAIL reset_dflt: got %b expected 1", dflt); end
    checks++; if (game_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", game_state); end
    reset = 1'b0; cycles(12); tick();
    checks++; if (game_state !== 2'd0) begin errors++; $display("FAIL idle_hold_state: got %0d expected 0", game_state); end
    checks++; if (p1_info !== 4'b0000) begin errors++; $display("FAIL idle_hold_p1: got %b expected 0000", p1_info); end
    checks++; if (dflt !== 1'b1) begin errors++; $display("FAIL idle_hold_dflt: got %b expected 1", dflt); end
    p1_btn = 4'b0000; cycles(10);
  endtask

  task automatic test_start();
    press_start();
    checks++; if (dflt !== 1'b0) begin errors++; $display("FAIL start_dflt: got %b expected 0", dflt); end
    checks++; if (p1_info !== 4'b0000) begin errors++; $display("FAIL start_pre_p1: got %b expected 0000", p1_info); end
    checks++; if (p2_info !== 4'b0000) begin errors++; $display("FAIL start_pre_p2: got %b expected 0000", p2_info); end
    checks++; if (game_state !== 2'd0) begin errors++; $display("FAIL start_pre_state: got %0d expected 0", game_state); end
    tick();
    checks++; if (p1_info !== 4'b0010) begin errors++; $display("FAIL start_p1: got %b expected 0010", p1_info); end
    checks++; if (p2_info !== 4'b0001) begin errors++; $display("FAIL start_p2: got %b expected 0001", p2_info); end
    checks++; if (game_state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d expected 1", game_state); end
  endtask

  task automatic test_illegal_reverse();
    press_p1(4'b0001);
    tick();
    checks++; if (p1_info !== 4'b0010) begin errors++; $display("FAIL reverse_drop: got %b expected 0010", p1_info); end
    press_p1(4'b0100);
    checks++; if (p1_info !== 4'b0010) begin errors++; $display("FAIL stable_between_ticks: got %b expected 0010", p1_info); end
    tick();
    checks++; if (p1_info !== 4'b0100) begin errors++; $display("FAIL up_commit: got %b expected 0100", p1_info); end
  endtask

  task automatic test_last_wins();
    press_p1(4'b1000);
    press_p1(4'b0001);
    press_p2(4'b0100);
    @(negedge clock); p1_btn = 4'b1000; cycles(2); p1_btn = 4'b0000; cycles(10);
    tick();
    checks++; if (p1_info !== 4'b0001) begin errors++; $display("FAIL last_wins_p1: got %b expected 0001", p1_info); end
    checks++; if (p2_info !== 4'b0100) begin errors++; $display("FAIL p2_up: got %b expected 0100", p2_info); end
  endtask

  task automatic test_priority();
    @(negedge clock); p1_btn = 4'b1011; p2_btn = 4'b0011; cycles(8);
    p1_btn = 4'b0000; p2_btn = 4'b0000; cycles(10);
    tick();
    checks++; if (p1_info !== 4'b1000) begin errors++; $display("FAIL prio_p1: got %b expected 1000", p1_info); end
    checks++; if (p2_info !== 4'b0001) begin errors++; $display("FAIL prio_p2: got %b expected 0001", p2_info); end
  endtask

  task automatic test_back_to_back();
    press_p1(4'b0001);
    @(negedge clock); frame_tick = 1'b1;
    @(negedge clock);
    checks++; if (p1_info !== 4'b0001) begin errors++; $display("FAIL b2b_first: got %b expected 0001", p1_info); end
    @(negedge clock); frame_tick = 1'b0;
    checks++; if (p1_info !== 4'b0001) begin errors++; $display("FAIL b2b_second: got %b expected 0001", p1_info); end
  endtask

  task automatic test_collision();
    press_p1(4'b1000);
    @(negedge clock); collision = 1'b1; frame_tick = 1'b1;
    @(negedge clock); collision = 1'b0; frame_tick = 1'b0;
    checks++; if (p1_info !== 4'b0000) begin errors++; $display("FAIL coll_p1: got %b expected 0000", p1_info); end
    checks++; if (p2_info !== 4'b0000) begin errors++; $display("FAIL coll_p2: got %b expected 0000", p2_info); end
    checks++; if (game_state !== 2'd2) begin errors++; $display("FAIL coll_state: got %0d expected 2", game_state); end
    checks++; if (dflt !== 1'b0) begin errors++; $display("FAIL over_dflt: got %b expected 0", dflt); end
    press_p1(4'b0100);
    tick();
    checks++; if (p1_info !== 4'b0000) begin errors++; $display("FAIL over_ignore: got %b expected 0000", p1_info); end
    checks++; if (game_state !== 2'd2) begin errors++; $display("FAIL over_hold: got %0d expected 2", game_state); end
    press_start();
    checks++; if (game_state !== 2'd0) begin errors++; $display("FAIL over_to_idle: got %0d expected 0", game_state); end
    checks++; if (dflt !== 1'b1) begin errors++; $display("FAIL idle_dflt: got %b expected 1", dflt); end
  endtask

  task automatic test_reset_mid_game();
    press_start(); tick();
    checks++; if (p1_info !== 4'b0010) begin errors++; $display("FAIL restart_p1: got %b expected 0010", p1_info); end
    checks++; if (game_state !== 2'd1) begin errors++; $display("FAIL restart_state: got %0d expected 1", game_state); end
    @(negedge clock); #2 reset = 1'b1; #1;
    checks++; if (p1_info !== 4'b0000) begin errors++; $display("FAIL async_p1: got %b expected 0000", p1_info); end
    checks++; if (dflt !== 1'b1) begin errors++; $display("FAIL async_dflt: got %b expected 1", dflt); end
    checks++; if (game_state !== 2'd0) begin errors++; $display("FAIL async_state: got %0d expected 0", game_state); end
    @(negedge clock); reset = 1'b0; cycles(2);
  endtask

`ifdef PAUSE_EN
  task automatic test_pause();
    press_start(); tick();
    checks++; if (p1_info !== 4'b0010) begin errors++; $display("FAIL pause_run_p1: got %b expected 0010", p1_info); end
    press_pause();
    checks++; if (game_state !== 2'd3) begin errors++; $display("FAIL pause_state: got %0d expected 3", game_state); end
    checks++; if (p1_info !== 4'b0000) begin errors++; $display("FAIL pause_p1: got %b expected 0000", p1_info); end
    @(negedge clock); collision = 1'b1; cycles(3); collision = 1'b0;
    checks++; if (game_state !== 2'd3) begin errors++; $display("FAIL pause_coll: got %0d expected 3", game_state); end
    press_p1(4'b0100);
    press_pause();
    checks++; if (game_state !== 2'd1) begin errors++; $display("FAIL resume_state: got %0d expected 1", game_state); end
    checks++; if (p1_info !== 4'b0000) begin errors++; $display("FAIL resume_pre: got %b expected 0000", p1_info); end
    tick();
    checks++; if (p1_info !== 4'b0100) begin errors++; $display("FAIL resume_p1: got %b expected 0100", p1_info); end
    checks++; if (p2_info !== 4'b0001) begin errors++; $display("FAIL resume_p2: got %b expected 0001", p2_info); end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_illegal_reverse();
    test_last_wins();
    test_priority();
    test_back_to_back();
    test_collision();
    test_reset_mid_game();
`ifdef PAUSE_EN
    test_pause();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
